// File: rtl/sort_pkg.sv
// Shared types and constants for the sort engine result path.
package sort_pkg;

  localparam int SORT_WORD_W = 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARM    = 2'd1,
    S_WAIT   = 2'd2,
    S_STREAM = 2'd3
  } rd_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sort_word_mux.sv
// Combinational element select: picks word idx out of a packed result vector.
// Zero latency; no flow control of its own.
module sort_word_mux
  import sort_pkg::*;
#(
  parameter int NUM   = 1024,
  parameter int IDX_W = idx_width(NUM)
) (
  input  logic [NUM*SORT_WORD_W-1:0] vec,
  input  logic [IDX_W-1:0]           idx,
  output logic [SORT_WORD_W-1:0]     word
);

  logic [SORT_WORD_W-1:0] elem [NUM];

  for (genvar k = 0; k < NUM; k++) begin : g_elem
    assign elem[k] = vec[k*SORT_WORD_W +: SORT_WORD_W];
  end

  assign word = elem[idx];

endmodule

// File: rtl/sort_result_reader.sv
// Streams TOTAL_NUM sorted words (index 0 first) once sort_done follows rd_start; first beat 1 cycle after done.
// Registered valid/ready master, outputs held under stall; SORT_READER_SNAPSHOT_EN copies the vector into a shadow at stream start.
module sort_result_reader
  import sort_pkg::*;
#(
  parameter  int TOTAL_NUM = 1024,
  localparam int IDX_W     = idx_width(TOTAL_NUM)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rd_start,
  input  logic                             sort_done,
  input  logic [TOTAL_NUM*SORT_WORD_W-1:0] sort_result,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [SORT_WORD_W-1:0]           m_data,
  output logic [IDX_W-1:0]                 m_idx,
  output logic                             m_last,
  output logic                             busy,
  output logic                             rd_done,
  output logic                             start_ovr
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_NUM - 1);

  rd_state_e                        state_q, state_d;
  logic                             load_first, beat_acc, last_acc;
  logic [IDX_W-1:0]                 next_idx;
  logic [SORT_WORD_W-1:0]           sel_word;
  logic [TOTAL_NUM*SORT_WORD_W-1:0] src_vec;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ARM always lasts one cycle so the previous run's lingering done is never seen.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (rd_start)  state_d = S_ARM;
      S_ARM:                   state_d = S_WAIT;
      S_WAIT:   if (sort_done) state_d = S_STREAM;
      S_STREAM: if (last_acc)  state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load_first = (state_q == S_WAIT) && sort_done;
    beat_acc   = (state_q == S_STREAM) && m_valid && m_ready;
    last_acc   = beat_acc && m_last;
    busy       = (state_q != S_IDLE);
    next_idx   = load_first ? '0 : m_idx + IDX_W'(1);
  end

`ifdef SORT_READER_SNAPSHOT_EN
  logic [TOTAL_NUM*SORT_WORD_W-1:0] shadow_q;

  always_ff @(posedge clk) begin
    if (load_first) shadow_q <= sort_result;
  end

  // The first word is fetched in the same cycle the shadow loads, so it comes from the live vector.
  assign src_vec = (state_q == S_STREAM) ? shadow_q : sort_result;
`else
  assign src_vec = sort_result;
`endif

  sort_word_mux #(
    .NUM   (TOTAL_NUM),
    .IDX_W (IDX_W)
  ) u_word_mux (
    .vec  (src_vec),
    .idx  (next_idx),
    .word (sel_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_idx     <= '0;
      m_last    <= 1'b0;
      rd_done   <= 1'b0;
      start_ovr <= 1'b0;
    end else begin
      rd_done   <= last_acc;
      start_ovr <= rd_start && (state_q != S_IDLE);
      if (load_first || beat_acc) begin
        m_data <= sel_word;
        m_idx  <= next_idx;
        m_last <= (next_idx == LAST_IDX);
      end
      if (load_first)    m_valid <= 1'b1;
      else if (last_acc) m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sort_result_reader.sv
// Directed and randomized bench for sort_result_reader at TOTAL_NUM=8; expected words come from the vector in index order.
module tb_sort_result_reader;

  localparam int TN = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            rd_start = 1'b0;
  logic            sort_done = 1'b0;
  logic [TN*32-1:0] sort_result;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic [31:0]     m_data;
  logic [2:0]      m_idx;
  logic            m_last;
  logic            busy;
  logic            rd_done;
  logic            start_ovr;

  logic [31:0] vec [TN];
  logic [31:0] exp_words [TN];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < TN; k++) sort_result[k*32 +: 32] = vec[k];
  end

  sort_result_reader #(.TOTAL_NUM(TN)) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_start    (rd_start),
    .sort_done   (sort_done),
    .sort_result (sort_result),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_idx       (m_idx),
    .m_last      (m_last),
    .busy        (busy),
    .rd_done     (rd_done),
    .start_ovr   (start_ovr)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_vec;
    for (int k = 0; k < TN; k++) vec[k] = $urandom;
  endtask

  // Pulse rd_start in the current cycle t; sort_done rises in cycle t+lat.
  // With stale set, done is also high in cycles t and t+1 (previous run's level).
  task automatic launch(input int lat, input bit stale);
    for (int k = 0; k < TN; k++) exp_words[k] = vec[k];
    rd_start  = 1'b1;
    sort_done = stale;
    step;
    rd_start  = 1'b0;
    sort_done = stale;
    check("arm_busy", busy, 1);
    check("arm_no_valid", m_valid, 0);
    for (int c = 2; c <= lat; c++) begin
      step;
      check("wait_no_valid", m_valid, 0);
      sort_done = (c == lat);
    end
    step;
    check("first_valid", m_valid, 1);
    check("first_idx", m_idx, 0);
    check("first_data", m_data, exp_words[0]);
  endtask

  // Consume one run; mode 0 = ready high, 1 = pattern 1,0,0,1, 2 = random.
  task automatic stream(input int mode, input int ovr_beat, input int snap_beat, input int max_cyc);
    int beats, ovr, cyc;
    bit hold, fin, sent, rdy, acc_last;
    logic [31:0] pd;
    logic [2:0]  pi;
    logic        pl;
    beats = 0; ovr = 0; cyc = 0;
    hold = 0; fin = 0; sent = 0;
    pd = '0; pi = '0; pl = 1'b0;
    while (!fin && cyc < max_cyc) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      m_ready = rdy;
      if (ovr_beat >= 0 && beats == ovr_beat && !sent) begin
        rd_start = 1'b1;
        sent = 1'b1;
      end
      if (snap_beat >= 0 && beats == snap_beat)
        for (int k = 0; k < TN; k++) vec[k] = 32'hFFFF_FFFF;
      check("valid_held", m_valid, 1);
      if (hold) begin
        check("stall_data", m_data, pd);
        check("stall_idx", m_idx, pi);
        check("stall_last", m_last, pl);
      end
      acc_last = 1'b0;
      if (m_valid && rdy) begin
        if (beats < TN) begin
          check("beat_data", m_data, exp_words[beats]);
          check("beat_idx", m_idx, beats);
          check("beat_last", m_last, (beats == TN - 1));
        end
        beats++;
        acc_last = (beats == TN);
      end
      hold = m_valid && !rdy;
      pd = m_data; pi = m_idx; pl = m_last;
      step;
      rd_start = 1'b0;
      cyc++;
      if (start_ovr) ovr++;
      if (acc_last) begin
        check("done_pulse", rd_done, 1);
        check("end_valid", m_valid, 0);
        check("end_busy", busy, 0);
        fin = 1'b1;
      end else begin
        check("no_early_done", rd_done, 0);
      end
    end
    check("stream_beats", beats, TN);
    check("ovr_pulses", ovr, (ovr_beat >= 0) ? 1 : 0);
  endtask

  initial begin
    for (int k = 0; k < TN; k++) vec[k] = '0;

    // Reset state
    step; step;
    check("rst_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", rd_done, 0);
    check("rst_ovr", start_ovr, 0);
    check("rst_idx", m_idx, 0);
    check("rst_data", m_data, 0);
    check("rst_last", m_last, 0);
    rst = 1'b0;
    step;
    check("post_rst_busy", busy, 0);

    // Basic stream
    for (int k = 0; k < TN; k++) vec[k] = 32'(80 - 10 * k);
    launch(5, 1'b0);
    stream(0, -1, -1, 40);
    // done level stays high in IDLE and must be ignored
    step; step;
    check("idle_ignores_done_busy", busy, 0);
    check("idle_ignores_done_valid", m_valid, 0);

    // Backpressure, then an immediate back-to-back restart
    rand_vec;
    launch(3, 1'b0);
    stream(1, -1, -1, 60);
    rand_vec;
    launch(2, 1'b0);
    stream(0, -1, -1, 40);

    // Stale done across rd_start
    rand_vec;
    launch(6, 1'b1);
    stream(0, -1, -1, 40);

    // Overrun during stream
    rand_vec;
    launch(4, 1'b0);
    stream(0, 3, -1, 40);

    // Reset mid-stream
    rand_vec;
    launch(3, 1'b0);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) step;
    check("pre_rst_idx", m_idx, 4);
    rst = 1'b1;
    step;
    rst = 1'b0;
    check("abort_valid", m_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", rd_done, 0);
    step;
    check("abort_done_late", rd_done, 0);
    rand_vec;
    launch(4, 1'b0);
    stream(0, -1, -1, 40);

    // Randomized ready and done latency
    for (int r = 0; r < 4; r++) begin
      rand_vec;
      launch(int'($urandom_range(2, 8)), 1'($urandom_range(0, 1)));
      stream(2, -1, -1, 300);
    end

`ifdef SORT_READER_SNAPSHOT_EN
    for (int k = 0; k < TN; k++) vec[k] = 32'(80 - 10 * k);
    launch(3, 1'b0);
    stream(0, -1, 3, 40);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
